id_stage: RTL
=============

Name: id_stage

Overview:
- RV32I decode stage; sits directly downstream of the fetch stage and consumes its pc/instr/valid.
- Decodes the instruction, generates the immediate, and reads a 32x32 register file with a WB write port and write-through bypass.
- Detects load-use hazards and drives the stall back to fetch; a one-entry replay register preserves the stalled instruction.
- Drives a registered ID/EX pipeline interface with 1-cycle latency.

Parameters:
RESET_PC, 32'h00000000, reset value of pc_o
NOP_INSTR, 32'h00000013, value of instr_o for bubbles and after reset

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-high
flush_i  in  1  kill the instruction in ID, clear replay
pc_i  in  32  PC from fetch
instr_i  in  32  instruction from fetch
valid_i  in  1  pc_i/instr_i valid
ex_rd_i  in  5  rd of instruction currently in EX
ex_mem_read_i  in  1  instruction in EX is a load
wb_we_i  in  1  register file write enable
wb_rd_i  in  5  write address
wb_data_i  in  32  write data
stall_o  out  1  combinational load-use stall to fetch
pc_o  out  32  PC to EX
instr_o  out  32  raw instruction to EX
rs1_data_o, rs2_data_o  out  32 each  operands
imm_o  out  32  sign-extended immediate
rs1_o, rs2_o, rd_o  out  5 each  register indices
funct3_o  out  3  funct3 passthrough
alu_op_o  out  4  ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9 PASSB=10
alu_src_imm_o  out  1  operand B = imm
alu_src_pc_o  out  1  operand A = pc (AUIPC, JAL)
reg_we_o, mem_read_o, mem_write_o, branch_o, jal_o, jalr_o  out  1 each  control
illegal_o  out  1  unsupported opcode/encoding
valid_o  out  1  ID/EX slot holds a real instruction

Behaviour:
- Reset (async): all outputs 0, except pc_o=RESET_PC and instr_o=NOP_INSTR. Register file cleared. Replay register empty.
- Source selection: replay register when replay_pending=1, else pc_i/instr_i/valid_i.
- Immediates:
  - I: instr[31:20], sign-extended.
  - S: {instr[31:25],instr[11:7]}.
  - B: {instr[31],instr[7],instr[30:25],instr[11:8],0}.
  - U: {instr[31:12],12'b0}.
  - J: {instr[31],instr[19:12],instr[20],instr[30:21],0}.
  - All sign-extended from bit 31.
- Decode:
  - Supported opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, FENCE (FENCE decoded as NOP with valid_o=1).
  - SUB/SRA/SRAI selected by instr[30].
  - LUI: PASSB + imm. AUIPC/JAL: ADD with pc as operand A.
- Register read: x0 always reads 0. Bypass when wb_we_i && wb_rd_i!=0 && wb_rd_i==rs -> operand = wb_data_i in the same cycle. Writes to x0 are ignored.
- rs usage: rs1 is used by all opcodes except LUI/AUIPC/JAL/FENCE. rs2 is used by BRANCH/STORE/OP only.
- Hazard: stall_o = src_valid && ex_mem_read_i && ex_rd_i!=0 && (rs1 used && ex_rd_i==rs1 || rs2 used && ex_rd_i==rs2) && !flush_i.
- Per-cycle update, in priority order:
  - flush_i: bubble (valid_o=0, all control 0, instr_o=NOP_INSTR); replay_pending <= 0.
  - stall_o: bubble; replay register <= source; replay_pending <= 1.
  - Otherwise: register the decoded source. If source invalid -> bubble. replay_pending <= 0.
- Illegal: valid_o=1, illegal_o=1; reg_we/mem_read/mem_write/branch/jal/jalr forced to 0.
- Latency: an instruction accepted at edge N appears on the outputs after edge N+1. A stall adds one bubble per stalled cycle.

Optional Feature:
ID_STRICT_DECODE_EN
- Defined: full funct7 check for OP and for shift-immediates (only 0x00, or 0x20 where legal). All other funct7 values -> illegal_o. FENCE requires funct3=0.
- Undefined: only instr[30] is inspected, so a nonzero funct7 decodes as the base op and illegal_o asserts only on unknown opcodes.

Test Plan:
1. Reset, then addi x1,x0,5 (0x00500093) valid -> next cycle valid_o=1, rd_o=1, imm_o=5, alu_op_o=ADD, alu_src_imm_o=1, reg_we_o=1.
2. WB writes x3=0xDEADBEEF in the same cycle as add x4,x3,x0 (0x00018233) is in ID -> rs1_data_o=0xDEADBEEF. WB write to x0 -> later read of x0 = 0.
3. ex_mem_read_i=1, ex_rd_i=5, ID holds add x6,x5,x7 (0x00728333) -> stall_o=1, one bubble (valid_o=0). valid_i dropped next cycle -> replayed add issues with rd_o=6.
4. flush_i asserted while replay_pending=1 -> valid_o=0, replay discarded, next valid fetch decoded normally.
5. beq x1,x2,-8 (0xFE208CE3) -> branch_o=1, imm_o=0xFFFFFFF8, alu_op_o=SUB. jal x1,+16 (0x010000EF) -> jal_o=1, imm_o=16, alu_src_pc_o=1.
6. 0x02000033 (funct7=0x01) -> with ID_STRICT_DECODE_EN: illegal_o=1, reg_we_o=0. Without: ADD, illegal_o=0. Assert rst_i mid-stall -> all outputs at reset values immediately.

Source files
------------

// File: rtl/id_stage.sv
// id_stage: RV32I decode with 32x32 regfile, WB write-through bypass, load-use stall and replay.
// Define ID_STRICT_DECODE_EN for full funct7 checks on OP/shift-imm and funct3 check on FENCE.
module id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  input  logic        valid_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        ex_mem_read_i,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_rd_i,
  input  logic [31:0] wb_data_i,
  output logic        stall_o,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic [31:0] rs1_data_o,
  output logic [31:0] rs2_data_o,
  output logic [31:0] imm_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rd_o,
  output logic [2:0]  funct3_o,
  output logic [3:0]  alu_op_o,
  output logic        alu_src_imm_o,
  output logic        alu_src_pc_o,
  output logic        reg_we_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        branch_o,
  output logic        jal_o,
  output logic        jalr_o,
  output logic        illegal_o,
  output logic        valid_o
);

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  typedef struct packed {
    logic        valid;
    logic        illegal;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [3:0]  alu_op;
    logic        src_imm;
    logic        src_pc;
    logic        reg_we;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jal;
    logic        jalr;
  } idex_t;

  logic [31:0] rf_q [32];
  logic        replay_q;
  logic [31:0] rpl_pc_q;
  logic [31:0] rpl_instr_q;
  idex_t       ex_q, ex_d, dec, bubble;

  logic        src_valid;
  logic [31:0] src_pc, src_instr;
  assign src_valid = replay_q | valid_i;
  assign src_pc    = replay_q ? rpl_pc_q : pc_i;
  assign src_instr = replay_q ? rpl_instr_q : instr_i;

  logic [6:0] opc;
  logic [2:0] f3;
  logic [4:0] rs1, rs2;
  assign opc = src_instr[6:0];
  assign f3  = src_instr[14:12];
  assign rs1 = src_instr[19:15];
  assign rs2 = src_instr[24:20];

  logic is_lui, is_auipc, is_jal, is_jalr, is_branch;
  logic is_load, is_store, is_opimm, is_op, is_fence;
  assign is_lui    = opc == 7'b0110111;
  assign is_auipc  = opc == 7'b0010111;
  assign is_jal    = opc == 7'b1101111;
  assign is_jalr   = opc == 7'b1100111;
  assign is_branch = opc == 7'b1100011;
  assign is_load   = opc == 7'b0000011;
  assign is_store  = opc == 7'b0100011;
  assign is_opimm  = opc == 7'b0010011;
  assign is_op     = opc == 7'b0110011;
  assign is_fence  = opc == 7'b0001111;

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = {{20{src_instr[31]}}, src_instr[31:20]};
  assign imm_s = {{20{src_instr[31]}}, src_instr[31:25], src_instr[11:7]};
  assign imm_b = {{19{src_instr[31]}}, src_instr[31], src_instr[7],
                  src_instr[30:25], src_instr[11:8], 1'b0};
  assign imm_u = {src_instr[31:12], 12'b0};
  assign imm_j = {{11{src_instr[31]}}, src_instr[31], src_instr[19:12],
                  src_instr[20], src_instr[30:21], 1'b0};

  logic bad_op, bad_opimm, bad_fence;
`ifdef ID_STRICT_DECODE_EN
  logic [6:0] f7;
  assign f7        = src_instr[31:25];
  assign bad_op    = !(f7 == 7'h00 ||
                       (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
  assign bad_opimm = (f3 == 3'b001 && f7 != 7'h00) ||
                     (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20);
  assign bad_fence = f3 != 3'b000;
`else
  assign bad_op    = 1'b0;
  assign bad_opimm = 1'b0;
  assign bad_fence = 1'b0;
`endif

  // x0 masking wins over the bypass, so a WB to x0 never leaks through
  logic [31:0] rs1_val, rs2_val;
  always_comb begin
    rs1_val = rf_q[rs1];
    if (wb_we_i && wb_rd_i == rs1) rs1_val = wb_data_i;
    if (rs1 == 5'd0) rs1_val = '0;
    rs2_val = rf_q[rs2];
    if (wb_we_i && wb_rd_i == rs2) rs2_val = wb_data_i;
    if (rs2 == 5'd0) rs2_val = '0;
  end

  logic [3:0] alu_f3;
  always_comb begin
    alu_f3 = ALU_ADD;
    unique case (f3)
      3'b000: alu_f3 = (is_op && src_instr[30]) ? ALU_SUB : ALU_ADD;
      3'b001: alu_f3 = ALU_SLL;
      3'b010: alu_f3 = ALU_SLT;
      3'b011: alu_f3 = ALU_SLTU;
      3'b100: alu_f3 = ALU_XOR;
      3'b101: alu_f3 = src_instr[30] ? ALU_SRA : ALU_SRL;
      3'b110: alu_f3 = ALU_OR;
      3'b111: alu_f3 = ALU_AND;
    endcase
  end

  logic illegal;
  always_comb begin
    dec          = '0;
    dec.valid    = 1'b1;
    dec.pc       = src_pc;
    dec.instr    = src_instr;
    dec.rs1      = rs1;
    dec.rs2      = rs2;
    dec.rd       = src_instr[11:7];
    dec.funct3   = f3;
    dec.rs1_data = rs1_val;
    dec.rs2_data = rs2_val;
    illegal      = 1'b0;
    unique case (1'b1)
      is_lui: begin
        dec.imm = imm_u; dec.alu_op = ALU_PASSB;
        dec.src_imm = 1'b1; dec.reg_we = 1'b1;
      end
      is_auipc: begin
        dec.imm = imm_u; dec.src_imm = 1'b1;
        dec.src_pc = 1'b1; dec.reg_we = 1'b1;
      end
      is_jal: begin
        dec.imm = imm_j; dec.src_imm = 1'b1; dec.src_pc = 1'b1;
        dec.reg_we = 1'b1; dec.jal = 1'b1;
      end
      is_jalr: begin
        dec.imm = imm_i; dec.src_imm = 1'b1;
        dec.reg_we = 1'b1; dec.jalr = 1'b1;
      end
      is_branch: begin
        dec.imm = imm_b; dec.alu_op = ALU_SUB; dec.branch = 1'b1;
      end
      is_load: begin
        dec.imm = imm_i; dec.src_imm = 1'b1;
        dec.reg_we = 1'b1; dec.mem_read = 1'b1;
      end
      is_store: begin
        dec.imm = imm_s; dec.src_imm = 1'b1; dec.mem_write = 1'b1;
      end
      is_opimm: begin
        dec.imm = imm_i; dec.alu_op = alu_f3;
        dec.src_imm = 1'b1; dec.reg_we = 1'b1;
        illegal = bad_opimm;
      end
      is_op: begin
        dec.alu_op = alu_f3; dec.reg_we = 1'b1;
        illegal = bad_op;
      end
      is_fence: begin
        dec.imm = imm_i;
        illegal = bad_fence;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      dec.illegal   = 1'b1;
      dec.imm       = '0;
      dec.alu_op    = ALU_ADD;
      dec.src_imm   = 1'b0;
      dec.src_pc    = 1'b0;
      dec.reg_we    = 1'b0;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
      dec.branch    = 1'b0;
      dec.jal       = 1'b0;
      dec.jalr      = 1'b0;
    end
  end

  logic use_rs1, use_rs2;
  assign use_rs1 = !(is_lui || is_auipc || is_jal || is_fence);
  assign use_rs2 = is_branch || is_store || is_op;

  assign stall_o = src_valid && ex_mem_read_i && ex_rd_i != 5'd0 &&
                   ((use_rs1 && ex_rd_i == rs1) ||
                    (use_rs2 && ex_rd_i == rs2)) && !flush_i;

  always_comb begin
    bubble       = '0;
    bubble.pc    = src_pc;
    bubble.instr = NOP_INSTR;
    ex_d         = bubble;
    if (!flush_i && !stall_o && src_valid) ex_d = dec;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wb_we_i && wb_rd_i != 5'd0) begin
      rf_q[wb_rd_i] <= wb_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_q        <= '0;
      ex_q.pc     <= RESET_PC;
      ex_q.instr  <= NOP_INSTR;
      replay_q    <= 1'b0;
      rpl_pc_q    <= '0;
      rpl_instr_q <= '0;
    end else begin
      ex_q <= ex_d;
      if (flush_i) begin
        replay_q <= 1'b0;
      end else if (stall_o) begin
        replay_q    <= 1'b1;
        rpl_pc_q    <= src_pc;
        rpl_instr_q <= src_instr;
      end else begin
        replay_q <= 1'b0;
      end
    end
  end

  assign valid_o       = ex_q.valid;
  assign illegal_o     = ex_q.illegal;
  assign pc_o          = ex_q.pc;
  assign instr_o       = ex_q.instr;
  assign rs1_data_o    = ex_q.rs1_data;
  assign rs2_data_o    = ex_q.rs2_data;
  assign imm_o         = ex_q.imm;
  assign rs1_o         = ex_q.rs1;
  assign rs2_o         = ex_q.rs2;
  assign rd_o          = ex_q.rd;
  assign funct3_o      = ex_q.funct3;
  assign alu_op_o      = ex_q.alu_op;
  assign alu_src_imm_o = ex_q.src_imm;
  assign alu_src_pc_o  = ex_q.src_pc;
  assign reg_we_o      = ex_q.reg_we;
  assign mem_read_o    = ex_q.mem_read;
  assign mem_write_o   = ex_q.mem_write;
  assign branch_o      = ex_q.branch;
  assign jal_o         = ex_q.jal;
  assign jalr_o        = ex_q.jalr;

endmodule
